// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer, control bits masked to zero on bubbles.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              Clk_40,
  input  logic              Reset_40,
  input  logic              Flush_40,
  input  logic              in_valid_40,
  output logic              in_ready_40,
  input  logic [DATA_W-1:0] data_in_40,
  input  logic [CTRL_W-1:0] ctrl_in_40,
  output logic              out_valid_40,
  input  logic              out_ready_40,
  output logic [DATA_W-1:0] data_out_40,
  output logic [CTRL_W-1:0] ctrl_out_40,
  output logic [1:0]        Count_40
);

  localparam int unsigned CNT_W   = 2;
  localparam bit          NO_SKID = (SKID == 0);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  head_data_q, head_data_d;
  logic [CTRL_W-1:0]  head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, ready_d;
  logic               ready_c;
  logic               in_xfer;
  logic               out_xfer;

  // Without skid, a full stage may still accept when the head leaves this cycle.
  assign ready_c  = (ready_q | (NO_SKID & out_ready_40)) & ~Flush_40 & Reset_40;
  assign in_xfer  = in_valid_40 & ready_c;
  assign out_xfer = valid_q & out_ready_40;

  always_ff @(posedge Clk_40 or negedge Reset_40) begin
    if (!Reset_40) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
    end
  end

  // Next state and entry updates; held entries are never rewritten.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d     = ONE;
          head_data_d = data_in_40;
          head_ctrl_d = ctrl_in_40;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_data_d = data_in_40;
          head_ctrl_d = ctrl_in_40;
        end else if (in_xfer) begin
          state_d     = TWO;
          skid_data_d = data_in_40;
          skid_ctrl_d = ctrl_in_40;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d     = ONE;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (Flush_40) begin
      state_d = EMPTY;
    end
  end

  // Registered status decoded from the next state.
  always_comb begin
    valid_d = (state_d != EMPTY);
    count_d = '0;
    case (state_d)
      ONE:     count_d = CNT_W'(1);
      TWO:     count_d = CNT_W'(2);
      default: count_d = '0;
    endcase
    ready_d = NO_SKID ? (state_d == EMPTY) : (state_d != TWO);
  end

  assign in_ready_40  = ready_c;
  assign out_valid_40 = valid_q;
  assign data_out_40  = head_data_q;
  assign ctrl_out_40  = head_ctrl_q & {CTRL_W{valid_q}};
  assign Count_40     = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances checked against a
// queue-based reference model under directed and random stimulus.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } slot_t;

  logic        Clk_40;
  logic        Reset_40;
  logic        Flush_40;
  logic        in_valid_40;
  logic [63:0] data_in_40;
  logic [7:0]  ctrl_in_40;
  logic        out_ready_40;

  logic        r1, v1, r0, v0;
  logic [63:0] d1, d0;
  logic [7:0]  c1, c0;
  logic [1:0]  n1, n0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  slot_t       q1[$];
  slot_t       q0[$];

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1)) dut1 (
    .Clk_40(Clk_40), .Reset_40(Reset_40), .Flush_40(Flush_40),
    .in_valid_40(in_valid_40), .in_ready_40(r1),
    .data_in_40(data_in_40), .ctrl_in_40(ctrl_in_40),
    .out_valid_40(v1), .out_ready_40(out_ready_40),
    .data_out_40(d1), .ctrl_out_40(c1), .Count_40(n1)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0)) dut0 (
    .Clk_40(Clk_40), .Reset_40(Reset_40), .Flush_40(Flush_40),
    .in_valid_40(in_valid_40), .in_ready_40(r0),
    .data_in_40(data_in_40), .ctrl_in_40(ctrl_in_40),
    .out_valid_40(v0), .out_ready_40(out_ready_40),
    .data_out_40(d0), .ctrl_out_40(c0), .Count_40(n0)
  );

  initial Clk_40 = 1'b0;
  always #5 Clk_40 = ~Clk_40;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs follow from queue occupancy and the handshake rules alone.
  task automatic check_dut(input string nm, input slot_t q[$], input bit skid, input bit rst,
                           input logic r, input logic v, input logic [63:0] d,
                           input logic [7:0] c, input logic [1:0] n, output bit er);
    er = rst && !Flush_40 &&
         (skid ? (q.size() < 2) : (q.size() == 0 || out_ready_40));
    chk({nm, " in_ready"}, 64'(r), 64'(er));
    chk({nm, " out_valid"}, 64'(v), 64'(q.size() > 0));
    chk({nm, " count"}, 64'(n), 64'(q.size()));
    if (q.size() > 0) begin
      chk({nm, " data"}, d, q[0].d);
      chk({nm, " ctrl"}, 64'(c), 64'(q[0].c));
    end else begin
      chk({nm, " ctrl_bubble"}, 64'(c), 64'(0));
      if (!rst) chk({nm, " data_reset"}, d, 64'(0));
    end
  endtask

  task automatic cycle(input bit rst, input bit iv, input logic [63:0] d, input logic [7:0] c,
                       input bit ordy, input bit fl);
    bit    er1, er0;
    slot_t s;
    @(negedge Clk_40);
    Reset_40     = rst;
    in_valid_40  = iv;
    data_in_40   = d;
    ctrl_in_40   = c;
    out_ready_40 = ordy;
    Flush_40     = fl;
    #1;
    if (!rst) begin
      q1.delete();
      q0.delete();
    end
    check_dut("skid1", q1, 1'b1, rst, r1, v1, d1, c1, n1, er1);
    check_dut("skid0", q0, 1'b0, rst, r0, v0, d0, c0, n0, er0);
    @(posedge Clk_40);
    s.d = d;
    s.c = c;
    if (rst) begin
      if (fl) begin
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() > 0 && ordy) void'(q1.pop_front());
        if (er1 && iv) q1.push_back(s);
        if (q0.size() > 0 && ordy) void'(q0.pop_front());
        if (er0 && iv) q0.push_back(s);
      end
    end
  endtask

  initial begin
    Reset_40     = 1'b0;
    Flush_40     = 1'b0;
    in_valid_40  = 1'b0;
    data_in_40   = '0;
    ctrl_in_40   = '0;
    out_ready_40 = 1'b0;

    // Reset held with valid input, then a streaming run.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 64'h1, 8'hFF, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 64'(i), 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    // Stall fill then drain.
    cycle(1'b1, 1'b1, 64'hAA, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'hBB, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'hDD, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    // Flush while full with a simultaneous input.
    cycle(1'b1, 1'b1, 64'hAA, 8'h44, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'hBB, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'hCC, 8'h66, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    // Bubble masking after drain.
    cycle(1'b1, 1'b1, 64'h1234, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);

    // Pass-through ready with out_ready toggling.
    cycle(1'b1, 1'b1, 64'h100, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h101, 8'h02, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 64'h102, 8'h03, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h103, 8'h04, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset while the skid stage is full.
    cycle(1'b1, 1'b1, 64'hE1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'hE2, 8'h88, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, 8'($urandom),
            ($urandom_range(0, 3) != 0) ^ (i[6] == 1'b1),
            ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
